// File: rtl/csa_resolver.sv
// csa_resolver -- resolves a carry-save pair (ps, sc) into a binary result,
// CHUNK bits per clock, LSB first, through an IDLE -> RUN -> DONE handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   sub                  (only with CSA_RESOLVER_SUB_EN) 1 = ps - sc
//   in_valid / in_ready  operand handshake; in_ready only in IDLE
//   ps, sc               carry-save operand pair, sampled only at acceptance
//   out_valid/out_ready  result handshake; out_valid only in DONE
//   result               WIDTH+1 bit result, held stable in DONE
//
// Optional feature macro: CSA_RESOLVER_SUB_EN adds the sub input.
// In subtract mode, sc is stored inverted and the carry is seeded with 1, and
// the top result bit becomes the sign, which is NOT of the final carry.
// WIDTH must be an integer multiple of CHUNK.
module csa_resolver #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CSA_RESOLVER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ps,
  input  logic [WIDTH-1:0] sc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0]  sc_q, sc_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [WIDTH:0]    result_q, result_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              sub_in;
  logic [CHUNK:0]    sum;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]  acc_nxt;

`ifdef CSA_RESOLVER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Low chunk of the shifting operand registers plus the stored carry.
  assign sum = {1'b0, ps_q[CHUNK-1:0]} + {1'b0, sc_q[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, carry_q};

  // New result chunk enters at the top; after NCH shifts the first chunk
  // has reached bit 0.
  assign acc_cat = {sum[CHUNK-1:0], acc_q};
  assign acc_nxt = acc_cat[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d     = state_q;
    ps_d        = ps_q;
    sc_d        = sc_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ps_d       = ps;
          sc_d       = sub_in ? ~sc : sc;
          sub_d      = sub_in;
          carry_d    = sub_in;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        ps_d    = ps_q >> CHUNK;
        sc_d    = sc_q >> CHUNK;
        acc_d   = acc_nxt;
        carry_d = sum[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NCH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = {sub_q ? ~sum[CHUNK] : sum[CHUNK], acc_nxt};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ps_q        <= '0;
      sc_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps_q        <= ps_d;
      sc_q        <= sc_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_csa_resolver.sv
module tb_csa_resolver;
  localparam int WIDTH = 8;
  localparam int CHUNK = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] ps = '0;
  logic [WIDTH-1:0] sc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   result;
`ifdef CSA_RESOLVER_SUB_EN
  logic             sub = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CSA_RESOLVER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ps        (ps),
    .sc        (sc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ps = a; sc = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 9'h000) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, want 1 0 000",
               in_ready, out_valid, result);
    end
    rst_n = 1'b1;
  endtask

  // 0F + 01, accepted on the very first edge after reset release.
  task automatic test_basic();
    int n;
    accept(8'h0F, 8'h01);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL first_accept: in_ready=%b want 0", in_ready);
    end
    wait_done(n);
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL basic_latency: got %0d edges want 4", n);
    end
    checks++;
    if (result !== 9'h010) begin
      errors++; $display("FAIL basic_result: got %h want 010", result);
    end
    drain();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  // FF + FF with in_valid held high: no re-acceptance until handshake.
  task automatic test_hold_in_valid();
    int n;
    ps = 8'hFF; sc = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    @(posedge clk); #1;  // extra DONE edge with in_valid still high
    checks++;
    if (out_valid !== 1'b1 || result !== 9'h1FE || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_done: out_valid=%b result=%h in_ready=%b want 1 1fe 0",
               out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_handshake: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;  // in_valid still high: accepted here
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_reaccept: in_ready=%b want 0", in_ready);
    end
    wait_done(n);
    drain();
  endtask

  // 04 + 05 with out_ready low for 3 DONE cycles.
  task automatic test_backpressure();
    int n;
    accept(8'h04, 8'h05);
    wait_done(n);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 9'h009 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_%0d: out_valid=%b result=%h in_ready=%b want 1 009 0",
                 i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  // Operands change right after acceptance; result must use captured values.
  task automatic test_operand_change();
    int n;
    accept(8'h02, 8'h04);
    ps = 8'hAA; sc = 8'h55;
    wait_done(n);
    checks++;
    if (result !== 9'h006) begin
      errors++; $display("FAIL operand_change: got %h want 006", result);
    end
    drain();
  endtask

  // Reset in the 2nd RUN cycle, then an immediate fresh operation.
  task automatic test_reset_mid_run();
    int n;
    accept(8'h0F, 8'h01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 9'h000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: out_valid=%b result=%h in_ready=%b want 0 000 1",
               out_valid, result, in_ready);
    end
    #2 rst_n = 1'b1;
    accept(8'h09, 8'h05);
    wait_done(n);
    checks++;
    if (n != 4 || result !== 9'h00E) begin
      errors++; $display("FAIL after_reset: n=%0d result=%h want 4 00e", n, result);
    end
    drain();
  endtask

  // out_ready high while IDLE does nothing.
  task automatic test_out_ready_idle();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 9'h00E) begin
      errors++;
      $display("FAIL out_ready_idle: in_ready=%b out_valid=%b result=%h want 1 0 00e",
               in_ready, out_valid, result);
    end
  endtask

  // Directed add vectors with hand-computed sums.
  task automatic test_vectors();
    logic [WIDTH-1:0] va [4] = '{8'h80, 8'h00, 8'h7F, 8'hAA};
    logic [WIDTH-1:0] vb [4] = '{8'h80, 8'h00, 8'h01, 8'h55};
    logic [WIDTH:0]   vr [4] = '{9'h100, 9'h000, 9'h080, 9'h0FF};
    int n;
    for (int i = 0; i < 4; i++) begin
      accept(va[i], vb[i]);
      wait_done(n);
      checks++;
      if (result !== vr[i]) begin
        errors++; $display("FAIL vector_%0d: got %h want %h", i, result, vr[i]);
      end
      drain();
    end
  endtask

`ifdef CSA_RESOLVER_SUB_EN
  task automatic test_sub();
    int n;
    sub = 1'b1;
    accept(8'h05, 8'h09);
    sub = 1'b0;
    wait_done(n);
    checks++;
    if (result !== 9'h1FC) begin
      errors++; $display("FAIL sub_neg: got %h want 1fc", result);
    end
    drain();
    sub = 1'b1;
    accept(8'h09, 8'h05);
    sub = 1'b0;
    wait_done(n);
    checks++;
    if (result !== 9'h004) begin
      errors++; $display("FAIL sub_pos: got %h want 004", result);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold_in_valid();
    test_backpressure();
    test_operand_change();
    test_reset_mid_run();
    test_out_ready_idle();
    test_vectors();
`ifdef CSA_RESOLVER_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
